// File: rtl/conv_fixew_pkg.sv
// rtl/conv_fixew_pkg.sv - shared widths and types for the 2-filter systolic convolution engine
package conv_fixew_pkg;
  localparam int N    = 8;
  localparam int ROWS = 8;
  localparam int COLS = 2;

  typedef logic signed [N-1:0]   feat_t;
  typedef logic signed [2*N-1:0] acc_t;
endpackage

// File: rtl/conv_pe.sv
// rtl/conv_pe.sv - weight-stationary MAC cell: registered partial sum and feature pass-through
module conv_pe
  import conv_fixew_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  feat_t fin,
  input  feat_t w,
  input  acc_t  psum_in,
  output feat_t fout,
  output acc_t  psum_out
);

  // Operands are widened before the multiply so the product is exact; the sum wraps modulo 2^(2N).
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_out <= '0;
      fout     <= '0;
    end else begin
      psum_out <= psum_in + acc_t'(fin) * acc_t'(w);
      fout     <= fin;
    end
  end

endmodule

// File: rtl/conv_fixew.sv
// rtl/conv_fixew.sv - 8x2 systolic array producing two skewed-input dot products per cycle
module conv_fixew
  import conv_fixew_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic signed [N-1:0]   F1,
  input  logic signed [N-1:0]   F2,
  input  logic signed [N-1:0]   F3,
  input  logic signed [N-1:0]   F4,
  input  logic signed [N-1:0]   F5,
  input  logic signed [N-1:0]   F6,
  input  logic signed [N-1:0]   F7,
  input  logic signed [N-1:0]   F8,
  input  logic signed [N-1:0]   W00,
  input  logic signed [N-1:0]   W01,
  input  logic signed [N-1:0]   W02,
  input  logic signed [N-1:0]   W03,
  input  logic signed [N-1:0]   W10,
  input  logic signed [N-1:0]   W11,
  input  logic signed [N-1:0]   W12,
  input  logic signed [N-1:0]   W13,
  input  logic signed [N-1:0]   G00,
  input  logic signed [N-1:0]   G01,
  input  logic signed [N-1:0]   G02,
  input  logic signed [N-1:0]   G03,
  input  logic signed [N-1:0]   G10,
  input  logic signed [N-1:0]   G11,
  input  logic signed [N-1:0]   G12,
  input  logic signed [N-1:0]   G13,
  output logic signed [2*N-1:0] C1,
  output logic signed [2*N-1:0] C2
);

  feat_t f_lane [ROWS];
  feat_t tap    [COLS][ROWS];
  feat_t fpass  [ROWS][COLS-1];
  feat_t f_unused [ROWS];
  acc_t  psum   [ROWS+1][COLS];

  assign f_lane = '{F1, F2, F3, F4, F5, F6, F7, F8};
  assign tap[0] = '{W00, W01, W02, W03, W10, W11, W12, W13};
  assign tap[1] = '{G00, G01, G02, G03, G10, G11, G12, G13};

  for (genvar j = 0; j < COLS; j++) begin : g_seed
    assign psum[0][j] = '0;
  end

  // Column j>0 sees each lane one cycle after column j-1, so its result trails by one cycle.
  for (genvar k = 0; k < ROWS; k++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      feat_t fin;
      feat_t fout;

      if (j == 0) begin : g_first
        assign fin = f_lane[k];
      end else begin : g_next
        assign fin = fpass[k][j-1];
      end

      if (j < COLS - 1) begin : g_pass
        assign fpass[k][j] = fout;
      end else begin : g_last
        assign f_unused[k] = fout;
      end

      conv_pe u_pe (
        .clk      (Clk),
        .rst      (Rst_n),
        .fin      (fin),
        .w        (tap[j][k]),
        .psum_in  (psum[k][j]),
        .fout     (fout),
        .psum_out (psum[k+1][j])
      );
    end
  end

  assign C1 = psum[ROWS][0];
  assign C2 = psum[ROWS][1];

endmodule

// File: tb/tb_conv_fixew.sv
// tb/tb_conv_fixew.sv - randomized and directed self-checking bench for conv_fixew
module tb_conv_fixew;
  logic              Clk = 1'b0;
  logic              Rst_n;
  logic signed [7:0] f_in [8];
  logic signed [7:0] w_in [8];
  logic signed [7:0] g_in [8];
  logic signed [15:0] c1;
  logic signed [15:0] c2;

  always #5 Clk = ~Clk;

  conv_fixew dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .F1(f_in[0]), .F2(f_in[1]), .F3(f_in[2]), .F4(f_in[3]),
    .F5(f_in[4]), .F6(f_in[5]), .F7(f_in[6]), .F8(f_in[7]),
    .W00(w_in[0]), .W01(w_in[1]), .W02(w_in[2]), .W03(w_in[3]),
    .W10(w_in[4]), .W11(w_in[5]), .W12(w_in[6]), .W13(w_in[7]),
    .G00(g_in[0]), .G01(g_in[1]), .G02(g_in[2]), .G03(g_in[3]),
    .G10(g_in[4]), .G11(g_in[5]), .G12(g_in[6]), .G13(g_in[7]),
    .C1(c1), .C2(c2)
  );

  int cyc = 0;
  int cur_v [8];
  int cur_w [8];
  int cur_g [8];
  bit cur_r;
  int vecs [1024][8];
  int hf   [1024][8];
  int hw   [1024][8];
  int hg   [1024][8];
  bit hr   [1024];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference: output after edge t is the sum over lanes of the sample each lane took on its
  // diagonal edge, dropping any term whose sample predates the most recent reset edge.
  function automatic logic [15:0] model_c(input int col, input int t);
    int lr  = 0;
    int sum = 0;
    int s;
    for (int x = t; x >= 1; x--) begin
      if (hr[x]) begin
        lr = x;
        break;
      end
    end
    for (int k = 0; k < 8; k++) begin
      s = (col == 1) ? t - 7 + k : t - 8 + k;
      if (s >= 1 && s > lr)
        sum += hf[s][k] * ((col == 1) ? hw[s][k] : hg[s + 1][k]);
    end
    return sum[15:0];
  endfunction

  task automatic set_vec(input int val);
    for (int k = 0; k < 8; k++) cur_v[k] = val;
  endtask

  task automatic set_w(input int val);
    for (int k = 0; k < 8; k++) cur_w[k] = val;
  endtask

  task automatic set_g(input int val);
    for (int k = 0; k < 8; k++) cur_g[k] = val;
  endtask

  // Lane k carries the vector that started k cycles before this edge (skewed feed).
  task automatic step();
    int nx;
    int lane [8];
    nx = cyc + 1;
    for (int k = 0; k < 8; k++) vecs[nx][k] = cur_v[k];
    for (int k = 0; k < 8; k++) begin
      lane[k] = (nx - k >= 0) ? vecs[nx - k][k] : 0;
      f_in[k] = 8'(lane[k]);
      w_in[k] = 8'(cur_w[k]);
      g_in[k] = 8'(cur_g[k]);
    end
    Rst_n = cur_r;
    @(posedge Clk);
    #1;
    cyc = nx;
    for (int k = 0; k < 8; k++) begin
      hf[cyc][k] = lane[k];
      hw[cyc][k] = cur_w[k];
      hg[cyc][k] = cur_g[k];
    end
    hr[cyc] = cur_r;
  endtask

  task automatic test_reset();
    set_vec(5); set_w(3); set_g(-2);
    cur_r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks += 2;
      if (c1 !== 16'sd0) begin n_fail++; $display("FAIL reset_c1 cyc=%0d got=%0d want=0", i, c1); end
      if (c2 !== 16'sd0) begin n_fail++; $display("FAIL reset_c2 cyc=%0d got=%0d want=0", i, c2); end
    end
    cur_r = 1'b0;
    step();
    n_checks += 2;
    if (c1 !== 16'sd0) begin n_fail++; $display("FAIL reset_release_c1 got=%0d want=0", c1); end
    if (c2 !== 16'sd0) begin n_fail++; $display("FAIL reset_release_c2 got=%0d want=0", c2); end
  endtask

  task automatic test_ramp();
    set_w(1); set_g(1); cur_r = 1'b0;
    for (int i = 0; i < 18; i++) begin
      set_vec(i <= 8 ? i : 0);
      step();
      if (i >= 7 && i <= 15) begin
        n_checks++;
        if (c1 !== 16'(8 * (i - 7))) begin
          n_fail++; $display("FAIL ramp_c1 j=%0d got=%0d want=%0d", i - 7, c1, 8 * (i - 7));
        end
      end
      if (i >= 8 && i <= 16) begin
        n_checks++;
        if (c2 !== 16'(8 * (i - 8))) begin
          n_fail++; $display("FAIL ramp_c2 j=%0d got=%0d want=%0d", i - 8, c2, 8 * (i - 8));
        end
      end
    end
  endtask

  task automatic test_distinct();
    for (int k = 0; k < 8; k++) cur_w[k] = k + 1;
    set_g(-1); cur_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_vec(i == 0 ? 1 : 0);
      step();
      if (i == 7) begin
        n_checks++;
        if (c1 !== 16'sd36) begin n_fail++; $display("FAIL distinct_c1 got=%0d want=36", c1); end
      end
      if (i == 8) begin
        n_checks++;
        if (c2 !== -16'sd8) begin n_fail++; $display("FAIL distinct_c2 got=%0d want=-8", c2); end
      end
    end
  endtask

  task automatic test_wrap();
    set_g(-1); cur_r = 1'b0;
    set_w(-128);
    for (int i = 0; i < 10; i++) begin
      set_vec(i == 0 ? -128 : 0);
      step();
      if (i == 7) begin
        n_checks++;
        if (c1 !== 16'sd0) begin n_fail++; $display("FAIL wrap_neg_c1 got=%0d want=0", c1); end
      end
      if (i == 8) begin
        n_checks++;
        if (c2 !== 16'sd1024) begin n_fail++; $display("FAIL wrap_neg_c2 got=%0d want=1024", c2); end
      end
    end
    set_w(127);
    for (int i = 0; i < 10; i++) begin
      set_vec(i == 0 ? -128 : 0);
      step();
      if (i == 7) begin
        n_checks++;
        if (c1 !== 16'h0400) begin n_fail++; $display("FAIL wrap_pos_c1 got=%0h want=0400", c1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_w(1); set_g(1); cur_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      set_vec(i < 3 ? i + 1 : 0);
      step();
      if (i >= 7 && i <= 9) begin
        n_checks++;
        if (c1 !== 16'(8 * (i - 6))) begin
          n_fail++; $display("FAIL b2b_c1 i=%0d got=%0d want=%0d", i, c1, 8 * (i - 6));
        end
      end
      if (i >= 8 && i <= 10) begin
        n_checks++;
        if (c2 !== 16'(8 * (i - 7))) begin
          n_fail++; $display("FAIL b2b_c2 i=%0d got=%0d want=%0d", i, c2, 8 * (i - 7));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] e1, e2;
    set_w(1); set_g(1);
    for (int i = 0; i < 22; i++) begin
      set_vec(i + 1);
      cur_r = (i == 10);
      step();
      if (i == 10) begin
        n_checks += 2;
        if (c1 !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_c1 got=%0d want=0", c1); end
        if (c2 !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_c2 got=%0d want=0", c2); end
      end else begin
        e1 = model_c(1, cyc);
        e2 = model_c(2, cyc);
        n_checks += 2;
        if (c1 !== e1) begin n_fail++; $display("FAIL mid_model_c1 i=%0d got=%0d want=%0d", i, c1, $signed(e1)); end
        if (c2 !== e2) begin n_fail++; $display("FAIL mid_model_c2 i=%0d got=%0d want=%0d", i, c2, $signed(e2)); end
      end
      if (i == 18) begin
        n_checks++;
        if (c1 !== 16'sd96) begin n_fail++; $display("FAIL mid_resume_c1 got=%0d want=96", c1); end
      end
      if (i == 19) begin
        n_checks++;
        if (c2 !== 16'sd96) begin n_fail++; $display("FAIL mid_resume_c2 got=%0d want=96", c2); end
      end
    end
    cur_r = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) begin
        cur_v[k] = int'($urandom_range(0, 255)) - 128;
        cur_w[k] = int'($urandom_range(0, 255)) - 128;
        cur_g[k] = int'($urandom_range(0, 255)) - 128;
      end
      cur_r = ($urandom_range(0, 39) == 0);
      step();
      e1 = model_c(1, cyc);
      e2 = model_c(2, cyc);
      n_checks += 2;
      if (c1 !== e1) begin n_fail++; $display("FAIL rand_c1 cyc=%0d got=%0d want=%0d", cyc, c1, $signed(e1)); end
      if (c2 !== e2) begin n_fail++; $display("FAIL rand_c2 cyc=%0d got=%0d want=%0d", cyc, c2, $signed(e2)); end
    end
  endtask

  initial begin
    for (int t = 0; t < 1024; t++) begin
      hr[t] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        vecs[t][k] = 0; hf[t][k] = 0; hw[t][k] = 0; hg[t][k] = 0;
      end
    end
    set_vec(0); set_w(0); set_g(0);
    cur_r = 1'b1;
    Rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      f_in[k] = '0; w_in[k] = '0; g_in[k] = '0;
    end
    test_reset();
    test_ramp();
    test_distinct();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
